// File: rtl/ln_wdma_pkg.sv
// Shared widths, burst stride and FSM encoding for the LayerNorm write DMA.
package ln_wdma_pkg;

    localparam int TOUT          = 32;
    localparam int MAX_DAT_DW    = 16;
    localparam int AXI_BURST_LEN = 16;
    localparam int LOG2_BURST    = 4;
    localparam int LOG2_CH_DIV   = 8;
    localparam int LOG2_H        = 12;
    localparam int LOG2_W        = 12;
    localparam int OSTD_MAX_DEF  = 8;

    localparam int DAT_W     = TOUT * MAX_DAT_DW;
    localparam int ADDR_W    = 32;
    localparam int CMD_LEN_W = LOG2_BURST;
    localparam int REQ_PD_W  = LOG2_BURST + 2 * ADDR_W;
    localparam int WB_W      = LOG2_W - LOG2_BURST;

    // Byte distance between consecutive W bursts of one row.
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(AXI_BURST_LEN * TOUT * MAX_DAT_DW / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT_RSP
    } state_t;

endpackage

// File: rtl/ln_wdma_addr_gen.sv
// Traversal counters (channel group innermost, then W burst, then H) producing
// the length and destination address of the current write command.
module ln_wdma_addr_gen
    import ln_wdma_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [25:0]            surface_stride,
    input  logic [15:0]            line_stride,
    input  logic [LOG2_CH_DIV-1:0] ch_div,
    input  logic [LOG2_H-1:0]      h_out,
    input  logic [LOG2_W-1:0]      w_out,
    output logic [CMD_LEN_W-1:0]   cmd_len,
    output logic [ADDR_W-1:0]      cmd_addr,
    output logic                   last
);

    logic [LOG2_CH_DIV-1:0] ch_cnt_reg;
    logic [WB_W-1:0]        w_burst_cnt_reg;
    logic [LOG2_H-1:0]      h_cnt_reg;
    logic [ADDR_W-1:0]      ch_bias_reg;
    logic [ADDR_W-1:0]      h_bias_reg;
    logic [WB_W-1:0]        w_burst_max;
    logic                   ch_wrap;
    logic                   w_wrap;
    logic                   h_wrap;

    assign w_burst_max = WB_W'((w_out - LOG2_W'(1)) >> LOG2_BURST);
    assign ch_wrap     = (ch_cnt_reg == ch_div - LOG2_CH_DIV'(1));
    assign w_wrap      = (w_burst_cnt_reg == w_burst_max);
    assign h_wrap      = (h_cnt_reg == h_out - LOG2_H'(1));
    assign last        = ch_wrap && w_wrap && h_wrap;

    // The low bits of w_out minus one wrap to all-ones on an exact multiple.
    assign cmd_len  = w_wrap ? (w_out[CMD_LEN_W-1:0] - CMD_LEN_W'(1)) : '1;
    assign cmd_addr = ch_bias_reg + h_bias_reg + ADDR_W'(w_burst_cnt_reg) * BURST_BYTES;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ch_cnt_reg      <= '0;
            w_burst_cnt_reg <= '0;
            h_cnt_reg       <= '0;
            ch_bias_reg     <= '0;
            h_bias_reg      <= '0;
        end else if (advance) begin
            if (ch_wrap) begin
                ch_cnt_reg  <= '0;
                ch_bias_reg <= '0;
                if (w_wrap) begin
                    w_burst_cnt_reg <= '0;
                    if (h_wrap) begin
                        h_cnt_reg  <= '0;
                        h_bias_reg <= '0;
                    end else begin
                        h_cnt_reg  <= h_cnt_reg + LOG2_H'(1);
                        h_bias_reg <= h_bias_reg + ADDR_W'(line_stride);
                    end
                end else begin
                    w_burst_cnt_reg <= w_burst_cnt_reg + WB_W'(1);
                end
            end else begin
                ch_cnt_reg  <= ch_cnt_reg + LOG2_CH_DIV'(1);
                ch_bias_reg <= ch_bias_reg + ADDR_W'(surface_stride);
            end
        end
    end

endmodule

// File: rtl/ln_wdma.sv
// LayerNorm write DMA: issues burst write commands, forwards result beats to the
// MCIF and signals done once every outstanding write has been acknowledged.
module ln_wdma
    import ln_wdma_pkg::*;
#(
    parameter int OSTD_MAX = OSTD_MAX_DEF
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [25:0]            surface_stride,
    input  logic [15:0]            line_stride,
    input  logic [LOG2_CH_DIV-1:0] CH_out_div_Tout,
    input  logic [LOG2_H-1:0]      h_out,
    input  logic [LOG2_W-1:0]      w_out,
    input  logic                   ln_dat_vld,
    output logic                   ln_dat_rdy,
    input  logic [DAT_W-1:0]       ln_dat_pd,
    output logic                   LN2mcif_wr_req_vld,
    input  logic                   LN2mcif_wr_req_rdy,
    output logic [REQ_PD_W-1:0]    LN2mcif_wr_req_pd,
    output logic                   LN2mcif_wr_dat_vld,
    input  logic                   LN2mcif_wr_dat_rdy,
    output logic [DAT_W-1:0]       LN2mcif_wr_dat_pd,
    input  logic                   mcif2LN_wr_rsp_vld,
    output logic                   busy,
    output logic                   done
);

    localparam int OSTD_W = $clog2(OSTD_MAX) + 1;

    state_t                 state_reg, state_next;
    logic [CMD_LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [OSTD_W-1:0]      ostd_cnt_reg;
    logic [CMD_LEN_W-1:0]   cmd_len;
    logic [ADDR_W-1:0]      cmd_addr;
    logic                   ag_last;
    logic                   ag_advance;
    logic                   ag_clear;
    logic                   req_hs;
    logic                   rsp_take;

    ln_wdma_addr_gen u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .clear          (ag_clear),
        .advance        (ag_advance),
        .surface_stride (surface_stride),
        .line_stride    (line_stride),
        .ch_div         (CH_out_div_Tout),
        .h_out          (h_out),
        .w_out          (w_out),
        .cmd_len        (cmd_len),
        .cmd_addr       (cmd_addr),
        .last           (ag_last)
    );

    assign LN2mcif_wr_req_pd = {cmd_len, base_addr, cmd_addr};
    assign busy              = (state_reg != ST_IDLE);
    assign req_hs            = LN2mcif_wr_req_vld && LN2mcif_wr_req_rdy;
    assign rsp_take          = mcif2LN_wr_rsp_vld && (ostd_cnt_reg != '0);

    // Payload is a straight lane-by-lane pass-through; only valid/ready are gated.
    genvar gi;
    generate
        for (gi = 0; gi < TOUT; gi++) begin : g_lane
            assign LN2mcif_wr_dat_pd[gi*MAX_DAT_DW +: MAX_DAT_DW] = ln_dat_pd[gi*MAX_DAT_DW +: MAX_DAT_DW];
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        beat_cnt_next      = beat_cnt_reg;
        LN2mcif_wr_req_vld = 1'b0;
        LN2mcif_wr_dat_vld = 1'b0;
        ln_dat_rdy         = 1'b0;
        ag_advance         = 1'b0;
        ag_clear           = 1'b0;
        done               = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CMD;
                    ag_clear   = 1'b1;
                end
            end
            ST_CMD: begin
                LN2mcif_wr_req_vld = (ostd_cnt_reg < OSTD_W'(OSTD_MAX));
                if (LN2mcif_wr_req_vld && LN2mcif_wr_req_rdy) begin
                    beat_cnt_next = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                LN2mcif_wr_dat_vld = ln_dat_vld;
                ln_dat_rdy         = LN2mcif_wr_dat_rdy;
                if (ln_dat_vld && LN2mcif_wr_dat_rdy) begin
                    if (beat_cnt_reg == cmd_len) begin
                        ag_advance = 1'b1;
                        state_next = ag_last ? ST_WAIT_RSP : ST_CMD;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CMD_LEN_W'(1);
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (ostd_cnt_reg == '0) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            beat_cnt_reg <= '0;
            ostd_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            if (req_hs && !rsp_take) begin
                ostd_cnt_reg <= ostd_cnt_reg + OSTD_W'(1);
            end else if (!req_hs && rsp_take) begin
                ostd_cnt_reg <= ostd_cnt_reg - OSTD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ln_wdma.sv
// Table-driven bench for ln_wdma with command/data scoreboards and hand-written
// sequences for outstanding limit, start-while-busy and mid-transfer reset.
module tb_ln_wdma;
    import ln_wdma_pkg::*;

    typedef struct packed {
        logic [11:0]       w;
        logic [11:0]       h;
        logic [7:0]        ch;
        logic [25:0]       ss;
        logic [15:0]       ls;
        logic [31:0]       base;
        logic [3:0]        n;
        logic [7:0][3:0]   len;
        logic [7:0][31:0]  addr;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [31:0]            base_addr = '0;
    logic [25:0]            surface_stride = '0;
    logic [15:0]            line_stride = '0;
    logic [LOG2_CH_DIV-1:0] ch_div = 8'd1;
    logic [LOG2_H-1:0]      h_out = 12'd1;
    logic [LOG2_W-1:0]      w_out = 12'd1;
    logic                   ln_dat_vld = 1'b0;
    logic                   ln_dat_rdy;
    logic [DAT_W-1:0]       ln_dat_pd = '0;
    logic                   req_vld;
    logic                   req_rdy = 1'b0;
    logic [REQ_PD_W-1:0]    req_pd;
    logic                   dat_vld;
    logic                   dat_rdy = 1'b0;
    logic [DAT_W-1:0]       dat_pd;
    logic                   rsp_vld = 1'b0;
    logic                   busy;
    logic                   done;

    ln_wdma #(.OSTD_MAX(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .base_addr          (base_addr),
        .surface_stride     (surface_stride),
        .line_stride        (line_stride),
        .CH_out_div_Tout    (ch_div),
        .h_out              (h_out),
        .w_out              (w_out),
        .ln_dat_vld         (ln_dat_vld),
        .ln_dat_rdy         (ln_dat_rdy),
        .ln_dat_pd          (ln_dat_pd),
        .LN2mcif_wr_req_vld (req_vld),
        .LN2mcif_wr_req_rdy (req_rdy),
        .LN2mcif_wr_req_pd  (req_pd),
        .LN2mcif_wr_dat_vld (dat_vld),
        .LN2mcif_wr_dat_rdy (dat_rdy),
        .LN2mcif_wr_dat_pd  (dat_pd),
        .mcif2LN_wr_rsp_vld (rsp_vld),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Shared between the test sequence and the interface engine.
    vec_t vecs [4];
    vec_t cur;
    int   vec_id = 0;
    bit   bp = 1'b0;
    bit   man_rdy = 1'b0;
    bit   man_req_rdy = 1'b0;
    bit   man_rsp_mode = 1'b0;
    bit   man_rsp = 1'b0;
    int   done_cnt = 0;
    int   req_cnt = 0;

    logic [REQ_PD_W-1:0] cmd_q [$];
    logic [DAT_W-1:0]    dat_q [$];
    int                  rsp_q [$];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DAT_W-1:0] rnd_beat();
        logic [DAT_W-1:0] r;
        for (int k = 0; k < DAT_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Interface engine: monitor at negedge, drive just after posedge.
    initial begin
        int  cyc = 0;
        int  seen_id = 0;
        int  model_ostd = 0;
        int  src_idx = 0;
        int  src_limit = 0;
        bit  src_acc = 1'b0;
        bit  prev_stall = 1'b0;
        logic [REQ_PD_W-1:0] prev_pd = '0;
        logic [DAT_W-1:0]    exp_beat;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_ostd = 0;
                prev_stall = 1'b0;
                src_acc    = 1'b0;
            end else begin
                check("ostd_cnt", 512'(dut.ostd_cnt_reg), 512'(model_ostd));
                if (prev_stall) check("req_pd_hold", {req_vld, req_pd}, {1'b1, prev_pd});
                prev_stall = req_vld && !req_rdy;
                prev_pd    = req_pd;
                if (req_vld && req_rdy) begin
                    req_cnt++;
                    rsp_q.push_back(cyc + 5);
                    if (cmd_q.size() == 0) check("cmd_extra", req_pd, '0);
                    else check("cmd", req_pd, cmd_q.pop_front());
                end
                if (dat_vld && dat_rdy) begin
                    if (dat_q.size() == 0) check("beat_extra", dat_pd, '0);
                    else begin
                        exp_beat = dat_q.pop_front();
                        check("beat", dat_pd, exp_beat);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_ostd", 512'(model_ostd), 512'(0));
                end
                src_acc = ln_dat_vld && ln_dat_rdy;
                if (req_vld && req_rdy && !(rsp_vld && model_ostd != 0)) model_ostd++;
                else if (!(req_vld && req_rdy) && rsp_vld && model_ostd != 0) model_ostd--;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (vec_id != seen_id) begin
                seen_id = vec_id;
                cmd_q.delete();
                dat_q.delete();
                rsp_q.delete();
                src_limit = 0;
                for (int k = 0; k < int'(cur.n); k++) begin
                    cmd_q.push_back({cur.len[k], cur.base, cur.addr[k]});
                    src_limit += int'(cur.len[k]) + 1;
                end
                src_idx    = 0;
                src_acc    = 1'b0;
                ln_dat_vld = 1'b0;
                done_cnt   = 0;
                req_cnt    = 0;
            end
            if (src_acc) begin
                ln_dat_vld = 1'b0;
                src_idx++;
            end
            if (!ln_dat_vld && src_idx < src_limit && (!bp || $urandom_range(9) >= 3)) begin
                ln_dat_pd  = rnd_beat();
                ln_dat_vld = 1'b1;
                dat_q.push_back(ln_dat_pd);
            end
            req_rdy = man_rdy ? man_req_rdy : (!bp || $urandom_range(9) >= 3);
            dat_rdy = !bp || $urandom_range(9) >= 3;
            rsp_vld = 1'b0;
            if (man_rsp_mode) begin
                if (man_rsp) begin
                    rsp_vld = 1'b1;
                    if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                end
            end else if (rsp_q.size() > 0 && cyc >= rsp_q[0]) begin
                rsp_vld = 1'b1;
                void'(rsp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mkv(int w, int h, int ch, int ss, int ls, logic [31:0] base);
        vec_t v = '0;
        v.w = 12'(w); v.h = 12'(h); v.ch = 8'(ch);
        v.ss = 26'(ss); v.ls = 16'(ls); v.base = base;
        return v;
    endfunction

    task automatic add(input int v, input int l, input logic [31:0] a);
        vecs[v].len[vecs[v].n]  = 4'(l);
        vecs[v].addr[vecs[v].n] = a;
        vecs[v].n               = vecs[v].n + 4'd1;
    endtask

    task automatic load(input vec_t v, input bit b);
        cur            = v;
        bp             = b;
        base_addr      = v.base;
        surface_stride = v.ss;
        line_stride    = v.ls;
        ch_div         = v.ch;
        h_out          = v.h;
        w_out          = v.w;
        vec_id++;
        tick();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            tick();
            n++;
        end
        check({nm, "_done_seen"}, done_cnt != 0, 1'b1);
        repeat (5) tick();
        check({nm, "_busy_end"}, busy, 1'b0);
        check({nm, "_done_once"}, 512'(done_cnt), 512'(1));
        check({nm, "_cmd_left"}, 512'(cmd_q.size()), 512'(0));
        check({nm, "_beat_left"}, 512'(dat_q.size()), 512'(0));
        check({nm, "_cmd_count"}, 512'(req_cnt), 512'(cur.n));
        $display("%s: commands=%0d cycles_to_done=%0d bad_so_far=%0d", nm, req_cnt, n, bad);
    endtask

    task automatic wait_req(input int target);
        int n = 0;
        while (req_cnt < target && n < 500) begin
            tick();
            n++;
        end
        check("req_count_reached", 512'(req_cnt), 512'(target));
    endtask

    initial begin
        vecs[0] = mkv(20, 1, 2, 32'h1000, 0, 32'h8000_0000);
        add(0, 15, 32'h0); add(0, 15, 32'h1000); add(0, 3, 32'h400); add(0, 3, 32'h1400);
        vecs[1] = mkv(16, 2, 1, 0, 32'h800, 32'h1234_5678);
        add(1, 15, 32'h0); add(1, 15, 32'h800);
        vecs[2] = mkv(40, 2, 1, 0, 32'h2000, 32'hCAFE_0000);
        add(2, 15, 32'h0); add(2, 15, 32'h400); add(2, 7, 32'h800);
        add(2, 15, 32'h2000); add(2, 15, 32'h2400); add(2, 7, 32'h2800);
        vecs[3] = mkv(5, 2, 3, 32'h100, 32'h40, 32'h0000_1000);
        add(3, 4, 32'h0); add(3, 4, 32'h100); add(3, 4, 32'h200);
        add(3, 4, 32'h40); add(3, 4, 32'h140); add(3, 4, 32'h240);

        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req_vld", req_vld, 1'b0);
        check("rst_dat_vld", dat_vld, 1'b0);
        check("rst_ln_rdy", ln_dat_rdy, 1'b0);
        rst = 1'b0;
        tick();

        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 4; v++) begin
                load(vecs[v], pass[0]);
                pulse_start();
                wait_done($sformatf("vec%0d_bp%0d", v, pass));
            end
        end

        // Outstanding limit with responses withheld, then a rsp coinciding with a req handshake.
        man_rdy = 1'b1; man_req_rdy = 1'b1; man_rsp_mode = 1'b1; man_rsp = 1'b0;
        load(mkv(64, 1, 1, 0, 0, 32'h4000_0000), 1'b0);
        add_cur(15, 32'h0); add_cur(15, 32'h400); add_cur(15, 32'h800); add_cur(15, 32'hC00);
        pulse_start();
        wait_req(2);
        repeat (40) tick();
        check("ostd_full_vld_low", req_vld, 1'b0);
        check("ostd_full_req_cnt", 512'(req_cnt), 512'(2));
        man_req_rdy = 1'b0;
        man_rsp = 1'b1;
        tick();
        man_rsp = 1'b0;
        tick();
        check("ostd_freed_vld_high", req_vld, 1'b1);
        man_rsp = 1'b1;
        man_req_rdy = 1'b1;
        tick();
        man_rsp = 1'b0;
        wait_req(4);
        repeat (30) tick();
        check("no_done_while_ostd", 512'(done_cnt), 512'(0));
        check("busy_while_ostd", busy, 1'b1);
        man_rsp_mode = 1'b0;
        man_rdy = 1'b0;
        wait_done("ostd_limit");

        // A second start mid-transfer must not restart the traversal.
        load(vecs[2], 1'b0);
        pulse_start();
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_restart", busy, 1'b1);
        wait_done("start_busy");

        // Reset during the second command's data phase, then a clean replay.
        load(vecs[0], 1'b0);
        pulse_start();
        wait_req(2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_req_vld", req_vld, 1'b0);
        check("midrst_dat_vld", dat_vld, 1'b0);
        check("midrst_ln_rdy", ln_dat_rdy, 1'b0);
        rst = 1'b0;
        tick();
        check("midrst_no_done", 512'(done_cnt), 512'(0));
        load(vecs[0], 1'b0);
        pulse_start();
        wait_done("replay_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Appends a command to the active vector; the engine reloads on the next vec_id bump.
    task automatic add_cur(input int l, input logic [31:0] a);
        cur.len[cur.n]  = 4'(l);
        cur.addr[cur.n] = a;
        cur.n           = cur.n + 4'd1;
        vec_id++;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
